spi_cfg_regbank: RTL and testbench
==================================

// Module: spi_cfg_regbank
// PURPOSE
// - Parametrised SPI configuration slave that generalises the fixed 3-register SPI block.
// - Holds NUM_REGS write/read registers of DATA_W bits, with burst auto-increment addressing and an error flag.
// - SPI pins are oversampled in the iclk domain, so the block runs on a single clock.
// - Sits between the chip pads and the config consumers (trigger mask, instruction, mode, ...).
// PARAMETERS
// - NUM_REGS   4    number of registers (2..128); address field is 7 bits wide.
// - DATA_W     8    register width (4..32); bits per data word on the wire.
// - ADDR_W     $clog2(NUM_REGS)    width of the select_reg output.
// PORTS
// - iclk            in   1                  system clock; must be >= 4x sclk.
// - rst             in   1                  async reset, active high.
// - sclk            in   1                  SPI clock, asynchronous to iclk.
// - cs_n            in   1                  SPI select, active low; frames the transaction.
// - serial_in       in   1                  MOSI, LSB first.
// - serial_out      out  1                  MISO, LSB first; 0 unless SPI_READBACK_EN.
// - regs_flat       out  NUM_REGS*DATA_W    register contents; reg k is at [k*DATA_W +: DATA_W].
// - wr_strobe       out  1                  1-cycle pulse when a register is committed.
// - select_reg      out  ADDR_W             address of the last committed write.
// - load_cnt_ser    out  8                  count of committed writes; wraps 255 -> 0.
// - addr_err        out  1                  sticky; set on access to address >= NUM_REGS.
// BEHAVIOUR
// - Sync: sclk, cs_n and serial_in each pass a 2-flop synchroniser.
//   - sclk rise = sync_sclk 0->1 (sampling edge); sclk fall = sync_sclk 1->0 (shift edge).
// - Reset values: all regs 0, serial_out 0, wr_strobe 0, select_reg 0, load_cnt_ser 0, addr_err 0, FSM in IDLE.
// - Frame: cs_n low, then 8-bit command, then one or more DATA_W data words, all LSB first.
//   - Command bits [6:0] = start address; bit 7 = R/W (1 = read).
// - FSM:
//   - IDLE -> CMD on a sync cs_n falling edge; clears the bit counter.
//   - CMD: shifts 8 bits on sclk rises. After bit 8: latch addr and rw, go to DATA.
//     - If addr >= NUM_REGS: set addr_err.
//   - DATA: shifts DATA_W bits. After the last bit of a write with a valid addr:
//     - the register is updated on the next iclk; wr_strobe pulses that cycle;
//     - select_reg takes addr; load_cnt_ser increments.
//     - Latency: 3 iclk from the raw last sclk rise to the regs_flat update.
//   - Burst: after each word, addr increments. NUM_REGS-1 wraps to 0; an out-of-range addr also wraps to 0. Stay in DATA.
//   - Any state -> IDLE on a sync cs_n rising edge; partial words are discarded with no commit.
// - Invalid address:
//   - Writes are dropped: no strobe, no count.
//   - Reads shift out zeros.
//   - addr_err is cleared only by rst.
// - A cs_n rise in the same iclk as the final bit's rise: the word commits first, then IDLE.
// - rst mid-frame: immediate return to reset values; the next frame needs a fresh cs_n falling edge.
// - sclk edges while cs_n is high are ignored.
// CONFIGURATION
// - SPI_READBACK_EN defined:
//   - For a read command, a shift register loads reg[addr] at CMD->DATA and at each burst advance.
//   - serial_out drives bit 0 first, before the first data rise, then the next bit on each sclk fall.
//   - serial_out is 0 outside DATA-read.
//   - Read words are never written.
// - SPI_READBACK_EN undefined:
//   - serial_out is tied to 0.
//   - Read commands complete silently: no register change, no strobe. addr_err is still flagged.
// TESTING (NUM_REGS=4, DATA_W=8, sclk = iclk/8)
// - Reset: pulse rst -> regs_flat=0x00000000, load_cnt_ser=0, addr_err=0, serial_out=0.
// - Write: cmd 0x01, data 0xAA
//   -> regs_flat=0x0000AA00, one wr_strobe, select_reg=1, load_cnt_ser=1.
// - Burst wrap: cmd 0x03, data 0x11, 0x22
//   -> reg3=0x11, reg0=0x22, load_cnt_ser += 2, final select_reg=0.
// - Abort: cmd 0x02, then 5 data bits, then cs_n high -> reg2 unchanged, no wr_strobe.
//   - A following full frame cmd 0x02, data 0x5C -> reg2=0x5C.
// - Bad address: cmd 0x05, data 0xFF -> addr_err=1, regs unchanged, load_cnt_ser unchanged.
//   - addr_err stays 1 after later valid frames.
// - Readback (SPI_READBACK_EN): after writing reg1=0xAA, cmd 0x81 -> serial_out yields 0xAA LSB first.
//   - Without the macro, serial_out stays 0.

Source files
------------

// File: rtl/spi_cfg_regbank.sv
// SPI configuration slave: NUM_REGS x DATA_W register bank, burst auto-increment, sticky address error.
// Optional SPI_READBACK_EN adds MISO readback; when it is undefined serial_out is tied low.
//
// state  | meaning
// S_IDLE | waiting for a cs_n falling edge
// S_CMD  | shifting in the 8-bit command (addr[6:0], rw)
// S_DATA | shifting data words, address advances after each word
module spi_cfg_regbank #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                         iclk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         serial_in,
    output logic                         serial_out,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            select_reg,
    output logic [7:0]                   load_cnt_ser,
    output logic                         addr_err
);

    localparam int SR_W = (DATA_W > 8) ? DATA_W : 8;
    localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t             state, state_nxt;
    logic [1:0]         sclk_sync, cs_sync, sin_sync;
    logic               sclk_prev, cs_prev;
    logic               sclk_rise, cs_fall, cs_rise;
    logic [SR_W-1:0]    sr, sr_next;
    logic [5:0]         bit_cnt;
    logic [6:0]         addr, burst_addr;
    logic               rw, addr_ok;
    logic               shift_en, cmd_done, word_done, clr_cnt, commit;
    logic [7:0]         cmd_byte;
    logic [DATA_W-1:0]  word;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    // cs sync flops reset low so a cs_n held low through reset is not seen as a new frame
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sin_sync  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            cs_sync   <= {cs_sync[0], cs_n};
            sin_sync  <= {sin_sync[0], serial_in};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign cs_fall   = cs_prev & ~cs_sync[1];
    assign cs_rise   = ~cs_prev & cs_sync[1];

    assign sr_next    = {sin_sync[1], sr[SR_W-1:1]};
    assign cmd_byte   = sr_next[SR_W-1 -: 8];
    assign word       = sr_next[SR_W-1 -: DATA_W];
    assign addr_ok    = ({1'b0, addr} < 8'(NUM_REGS));
    assign burst_addr = ({1'b0, addr} >= 8'(NUM_REGS - 1)) ? 7'd0 : addr + 7'd1;
    assign commit     = word_done & ~rw & addr_ok;

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cs_fall) state_nxt = S_CMD;
            S_CMD:   if (cs_rise) state_nxt = S_IDLE;
                     else if (cmd_done) state_nxt = S_DATA;
            S_DATA:  if (cs_rise) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        cmd_done  = 1'b0;
        word_done = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            S_IDLE: clr_cnt = cs_fall;
            S_CMD: begin
                shift_en = sclk_rise;
                cmd_done = sclk_rise && (bit_cnt == 6'd7);
            end
            S_DATA: begin
                shift_en  = sclk_rise;
                word_done = sclk_rise && (bit_cnt == LAST_BIT);
            end
            default: ;
        endcase
    end

    // the final bit is taken from sr_next so the commit lands on the same edge it is shifted in
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            sr           <= '0;
            bit_cnt      <= '0;
            addr         <= '0;
            rw           <= 1'b0;
            wr_strobe    <= 1'b0;
            select_reg   <= '0;
            load_cnt_ser <= '0;
            addr_err     <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (clr_cnt || cmd_done || word_done) bit_cnt <= '0;
            else if (shift_en)                     bit_cnt <= bit_cnt + 6'd1;
            if (shift_en) sr <= sr_next;
            if (cmd_done) begin
                addr <= cmd_byte[6:0];
                rw   <= cmd_byte[7];
                if ({1'b0, cmd_byte[6:0]} >= 8'(NUM_REGS)) addr_err <= 1'b1;
            end
            if (word_done) addr <= burst_addr;
            if (commit) begin
                regs[addr[ADDR_W-1:0]] <= word;
                wr_strobe              <= 1'b1;
                select_reg             <= addr[ADDR_W-1:0];
                load_cnt_ser           <= load_cnt_ser + 8'd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[k*DATA_W +: DATA_W] = regs[k];
    end

`ifdef SPI_READBACK_EN
    logic              sclk_fall;
    logic [DATA_W-1:0] rd_sr;

    assign sclk_fall = ~sclk_sync[1] & sclk_prev;

    // no shift on the fall that precedes a word's first rise: bit 0 must stay on the pin
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            rd_sr <= '0;
        end else if (cmd_done && cmd_byte[7]) begin
            rd_sr <= ({1'b0, cmd_byte[6:0]} < 8'(NUM_REGS)) ? regs[cmd_byte[ADDR_W-1:0]] : '0;
        end else if (word_done && rw) begin
            rd_sr <= regs[burst_addr[ADDR_W-1:0]];
        end else if (sclk_fall && state == S_DATA && rw && bit_cnt != 6'd0) begin
            rd_sr <= {1'b0, rd_sr[DATA_W-1:1]};
        end
    end

    assign serial_out = (state == S_DATA && rw) ? rd_sr[0] : 1'b0;
`else
    assign serial_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Self-checking bench for spi_cfg_regbank (NUM_REGS=4, DATA_W=8, sclk = iclk/8).
// Directed frames plus randomized frames checked against an array-based reference model.
module tb_spi_cfg_regbank;

`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        iclk, rst, sclk, cs_n, serial_in;
    logic        serial_out, wr_strobe, addr_err;
    logic [31:0] regs_flat;
    logic [1:0]  select_reg;
    logic [7:0]  load_cnt_ser;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;

    int exp_regs [4];
    int exp_cnt, exp_sel, exp_err, exp_strobes;
    int wbuf [8];

    spi_cfg_regbank #(.NUM_REGS(4), .DATA_W(8)) dut (
        .iclk(iclk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .serial_in(serial_in),
        .serial_out(serial_out), .regs_flat(regs_flat), .wr_strobe(wr_strobe),
        .select_reg(select_reg), .load_cnt_ser(load_cnt_ser), .addr_err(addr_err)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(negedge iclk) if (wr_strobe) strobe_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_regs[i] = 0;
        exp_cnt = 0;
        exp_sel = 0;
        exp_err = 0;
    endtask

    task automatic check_state(input string tag);
        logic [31:0] flat;
        flat = {exp_regs[3][7:0], exp_regs[2][7:0], exp_regs[1][7:0], exp_regs[0][7:0]};
        check_val({tag, ".regs"}, regs_flat, flat);
        check_val({tag, ".cnt"}, {24'd0, load_cnt_ser}, exp_cnt);
        check_val({tag, ".sel"}, {30'd0, select_reg}, exp_sel);
        check_val({tag, ".err"}, {31'd0, addr_err}, exp_err);
        check_val({tag, ".strobes"}, strobe_cnt, exp_strobes);
    endtask

    // one bit per 8 iclk; serial_out is captured just before each rise
    task automatic send_bits(input logic [31:0] d, input int n, output logic [31:0] rd,
                             input bit cs_on_last);
        rd = '0;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            serial_in = d[i];
            repeat (4) @(negedge iclk);
            rd[i] = serial_out;
            sclk = 1'b1;
            if (cs_on_last && i == n - 1) cs_n = 1'b1;
            repeat (4) @(negedge iclk);
        end
    endtask

    task automatic do_frame(input string tag, input logic [7:0] cmd, input int nwords,
                            input int abort_bits, input bit cs_on_last);
        logic [31:0] rd;
        int maddr, exp_rd;
        bit mrw;
        cs_n = 1'b0;
        repeat (4) @(negedge iclk);
        send_bits({24'd0, cmd}, 8, rd, 1'b0);
        maddr = int'(cmd[6:0]);
        mrw = cmd[7];
        if (maddr >= 4) exp_err = 1;
        for (int w = 0; w < nwords; w++) begin
            exp_rd = (RB && mrw && maddr < 4) ? exp_regs[maddr] : 0;
            send_bits(wbuf[w], 8, rd, cs_on_last && (w == nwords - 1));
            check_val({tag, ".miso"}, rd, exp_rd);
            if (!mrw && maddr < 4) begin
                exp_regs[maddr] = wbuf[w] & 8'hFF;
                exp_cnt = (exp_cnt + 1) % 256;
                exp_sel = maddr;
                exp_strobes++;
            end
            maddr = (maddr >= 3) ? 0 : maddr + 1;
        end
        if (abort_bits > 0) send_bits($urandom, abort_bits, rd, 1'b0);
        sclk = 1'b0;
        repeat (4) @(negedge iclk);
        cs_n = 1'b1;
        repeat (8) @(negedge iclk);
        check_state(tag);
    endtask

    initial begin
        logic [31:0] rd;
        int a, nw, ab;
        bit r;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; serial_in = 1'b0;
        exp_strobes = 0;
        model_reset();
        repeat (3) @(negedge iclk);
        check_val("rst.serial_out", {31'd0, serial_out}, 0);
        check_val("rst.strobe", {31'd0, wr_strobe}, 0);
        rst = 1'b0;
        repeat (4) @(negedge iclk);
        check_state("reset");

        wbuf[0] = 'hAA;
        do_frame("write1", 8'h01, 1, 0, 1'b0);

        wbuf[0] = 'h11; wbuf[1] = 'h22;
        do_frame("burst_wrap", 8'h03, 2, 0, 1'b0);

        do_frame("abort", 8'h02, 0, 5, 1'b0);
        wbuf[0] = 'h5C;
        do_frame("after_abort", 8'h02, 1, 0, 1'b0);

        wbuf[0] = 'hFF;
        do_frame("bad_addr", 8'h05, 1, 0, 1'b0);
        wbuf[0] = 'h77;
        do_frame("err_sticky", 8'h00, 1, 0, 1'b0);

        wbuf[0] = 'hAA;
        do_frame("wr_reg1", 8'h01, 1, 0, 1'b0);
        do_frame("readback", 8'h81, 1, 0, 1'b0);
        wbuf[0] = 'h00; wbuf[1] = 'h00; wbuf[2] = 'h00;
        do_frame("read_burst", 8'h82, 3, 0, 1'b0);

        wbuf[0] = 'h3C;
        do_frame("cs_on_last", 8'h00, 1, 0, 1'b1);

        // sclk activity with cs_n high must be ignored
        send_bits(32'h0000_A501, 8, rd, 1'b0);
        send_bits(32'h0000_00FF, 8, rd, 1'b0);
        sclk = 1'b0;
        repeat (8) @(negedge iclk);
        check_state("cs_high");

        // reset mid-frame, cs_n held low across it
        cs_n = 1'b0;
        repeat (4) @(negedge iclk);
        send_bits(32'h0000_0001, 8, rd, 1'b0);
        send_bits(32'h0000_000F, 4, rd, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge iclk);
        rst = 1'b0;
        model_reset();
        send_bits(32'h0000_00C3, 8, rd, 1'b0);
        send_bits(32'h0000_0099, 8, rd, 1'b0);
        sclk = 1'b0;
        repeat (4) @(negedge iclk);
        cs_n = 1'b1;
        repeat (8) @(negedge iclk);
        check_state("mid_rst");
        wbuf[0] = 'h96;
        do_frame("post_rst", 8'h02, 1, 0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            a  = $urandom_range(0, 5);
            r  = ($urandom_range(0, 3) == 0);
            nw = $urandom_range(1, 3);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            for (int w = 0; w < nw; w++) wbuf[w] = $urandom & 'hFF;
            do_frame("rand", {r, 7'(a)}, nw, ab, ($urandom_range(0, 5) == 0) && (ab == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
